signal_cfg_sequencer: RTL and testbench

SIGNAL_CFG_SEQUENCER -- requirements
Module: signal_cfg_sequencer

---
 rtl/signal_cfg_sequencer_pkg.sv | 19 +
 rtl/cfg_timeout_counter.sv | 32 +++
 rtl/signal_cfg_sequencer.sv | 145 ++++++++++++++
 tb/tb_signal_cfg_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/signal_cfg_sequencer_pkg.sv
// Shared types and sizes for the signal configuration sequencer.
package signal_cfg_sequencer_pkg;

    localparam int CFG_WIDTH = 832;
    localparam int WORD_W    = 32;
    localparam int ADDR_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Bit offset of a 32-bit word inside the configuration vector.
    function automatic logic [ADDR_W+4:0] word_lsb(input logic [ADDR_W-1:0] idx);
        return {idx, 5'd0};
    endfunction

endpackage

// File: rtl/cfg_timeout_counter.sv
// Counts ARMED cycles and flags the cycle in which the wait budget runs out.
module cfg_timeout_counter #(
    parameter int CYCLES = 0
) (
    input  logic aclk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam logic [31:0] LOAD_VAL = (CYCLES > 0) ? 32'(CYCLES - 1) : 32'd0;
    localparam logic        ACTIVE   = (CYCLES > 0) ? 1'b1 : 1'b0;

    logic [31:0] remaining_r;

    // Remaining-cycle down counter, reloaded on every entry to ARMED.
    always_ff @(posedge aclk) begin
        if (reset) begin
            remaining_r <= 32'd0;
        end else if (load) begin
            remaining_r <= LOAD_VAL;
        end else if (enable && (remaining_r != 32'd0)) begin
            remaining_r <= remaining_r - 32'd1;
        end else begin
            remaining_r <= remaining_r;
        end
    end

    assign expire = ACTIVE & enable & (remaining_r == 32'd0);

endmodule

// File: rtl/signal_cfg_sequencer.sv
// Shadow/active configuration vector with immediate or period-synchronised atomic commit.
module signal_cfg_sequencer
    import signal_cfg_sequencer_pkg::*;
#(
    parameter int NUM_WORDS      = 26,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [WORD_W-1:0]    wr_data,
    input  logic                 commit_req,
    input  logic                 commit_mode,
    input  logic                 sync_pulse,
    input  logic                 abort,
    output logic [CFG_WIDTH-1:0] cfg_data,
    output logic                 pending,
    output logic                 commit_done,
    output logic                 wr_err,
    output logic                 timeout,
    output logic [15:0]          commit_count
);

    localparam logic [ADDR_W:0] NUM_WORDS_W = (ADDR_W + 1)'(NUM_WORDS);

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CFG_WIDTH-1:0] shadow_r;
    logic [CFG_WIDTH-1:0] shadow_fwd_s;
    logic [CFG_WIDTH-1:0] cfg_r;
    logic [15:0]          count_r;
    logic                 pending_r;
    logic                 wr_ready_r;
    logic                 commit_done_r;
    logic                 wr_err_r;
    logic                 wr_acc_s;
    logic                 addr_ok_s;
    logic                 copy_s;
    logic                 timeout_s;
    logic                 load_s;
    logic                 enable_s;
    logic                 expire_s;

    assign wr_acc_s  = wr_valid & wr_ready_r;
    assign addr_ok_s = ({1'b0, wr_addr} < NUM_WORDS_W);

    // Shadow with this cycle's write applied, so an immediate copy sees it.
    always_comb begin
        shadow_fwd_s = shadow_r;
        if (wr_acc_s && addr_ok_s) begin
            shadow_fwd_s[word_lsb(wr_addr) +: WORD_W] = wr_data;
        end else begin
            shadow_fwd_s = shadow_r;
        end
    end

    // Next-state decode; abort beats sync_pulse, sync_pulse beats expiry.
    always_comb begin
        state_nxt_s = state_r;
        copy_s      = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (commit_req) begin
                    if (commit_mode) begin
                        state_nxt_s = ST_ARMED;
                    end else begin
                        copy_s      = 1'b1;
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                end else if (sync_pulse) begin
                    copy_s      = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (expire_s) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign load_s   = (state_r != ST_ARMED) && (state_nxt_s == ST_ARMED);
    assign enable_s = (state_r == ST_ARMED);

    cfg_timeout_counter #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .aclk   (aclk),
        .reset  (reset),
        .load   (load_s),
        .enable (enable_s),
        .expire (expire_s)
    );

    // State, shadow, active vector and status registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            shadow_r      <= '0;
            cfg_r         <= '0;
            count_r       <= 16'd0;
            pending_r     <= 1'b0;
            wr_ready_r    <= 1'b1;
            commit_done_r <= 1'b0;
            wr_err_r      <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            shadow_r      <= shadow_fwd_s;
            if (copy_s) begin
                cfg_r   <= shadow_fwd_s;
                count_r <= count_r + 16'd1;
            end else begin
                cfg_r   <= cfg_r;
                count_r <= count_r;
            end
            pending_r     <= (state_nxt_s == ST_ARMED);
            wr_ready_r    <= (state_nxt_s != ST_ARMED);
            commit_done_r <= copy_s;
            wr_err_r      <= wr_acc_s & ~addr_ok_s;
        end
    end

    assign cfg_data     = cfg_r;
    assign pending      = pending_r;
    assign wr_ready     = wr_ready_r;
    assign commit_done  = commit_done_r;
    assign wr_err       = wr_err_r;
    assign timeout      = timeout_s;
    assign commit_count = count_r;

endmodule

// File: tb/tb_signal_cfg_sequencer.sv
// Directed, table-driven bench for signal_cfg_sequencer (timeout off and timeout = 4 instances).
module tb_signal_cfg_sequencer;

    logic         aclk = 1'b0;
    logic         reset;
    logic         wr_valid;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         commit_req;
    logic         commit_mode;
    logic         sync_pulse;
    logic         abort;

    logic         wr_ready_0, pending_0, commit_done_0, wr_err_0, timeout_0;
    logic [831:0] cfg_0;
    logic [15:0]  cnt_0;
    logic         wr_ready_4, pending_4, commit_done_4, wr_err_4, timeout_4;
    logic [831:0] cfg_4;
    logic [15:0]  cnt_4;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    signal_cfg_sequencer #(.NUM_WORDS(26), .TIMEOUT_CYCLES(0)) dut0 (
        .aclk(aclk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_0),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req),
        .commit_mode(commit_mode), .sync_pulse(sync_pulse), .abort(abort),
        .cfg_data(cfg_0), .pending(pending_0), .commit_done(commit_done_0),
        .wr_err(wr_err_0), .timeout(timeout_0), .commit_count(cnt_0)
    );

    signal_cfg_sequencer #(.NUM_WORDS(26), .TIMEOUT_CYCLES(4)) dut4 (
        .aclk(aclk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_4),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req),
        .commit_mode(commit_mode), .sync_pulse(sync_pulse), .abort(abort),
        .cfg_data(cfg_4), .pending(pending_4), .commit_done(commit_done_4),
        .wr_err(wr_err_4), .timeout(timeout_4), .commit_count(cnt_4)
    );

    typedef struct packed {
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        cr;
        logic        cm;
        logic        sp;
        logic        ab;
        logic        e_rdy;
        logic        e_pend;
        logic        e_done;
        logic        e_err;
        logic [15:0] e_cnt;
        logic [4:0]  e_idx;
        logic [31:0] e_word;
    } vec_t;

    vec_t vecs [0:26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [831:0] act, input logic [831:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cfg_data differs, low words got %h expected %h", name, act[127:0], exp[127:0]);
        end
    endtask

    task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                         input logic cr, input logic cm, input logic sp, input logic ab);
        @(negedge aclk);
        wr_valid    = wv;
        wr_addr     = wa;
        wr_data     = wd;
        commit_req  = cr;
        commit_mode = cm;
        sync_pulse  = sp;
        abort       = ab;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        reset = 1'b1;
        repeat (2) @(negedge aclk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input logic [831:0] v, input int idx);
        return v[idx*32 +: 32];
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [831:0] exp_cfg;

        //            wv    wa     wd            cr    cm    sp    ab    rdy   pend  done  err   cnt     idx   word
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 5'd1, 32'h0};
        vecs[1]  = '{1'b1, 5'd1,  32'h1234ABCD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 5'd1, 32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 5'd1, 32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 5'd1, 32'h1234ABCD};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 5'd1, 32'h1234ABCD};
        vecs[5]  = '{1'b1, 5'd26, 32'h55555555, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 5'd0, 32'h0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1, 5'd0, 32'h0};
        vecs[7]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 5'd0, 32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 5'd0, 32'hFFFFFFFF};
        vecs[9]  = '{1'b1, 5'd2,  32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 5'd2, 32'h0};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 5'd2, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 5'd2, 32'h0};
        vecs[12] = '{1'b1, 5'd2,  32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 5'd2, 32'h0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 5'd2, 32'h0};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3, 5'd2, 32'hA5A5A5A5};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 5'd2, 32'hA5A5A5A5};
        vecs[16] = '{1'b1, 5'd3,  32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 5'd3, 32'h0};
        vecs[17] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 5'd3, 32'h0};
        vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 5'd3, 32'h0};
        vecs[19] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 5'd3, 32'h0};
        vecs[20] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 5'd3, 32'h0};
        vecs[21] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 5'd3, 32'h0};
        vecs[22] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 5'd3, 32'h0};
        vecs[23] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 5'd3, 32'h0BADF00D};
        vecs[24] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 5'd3, 32'h0BADF00D};
        vecs[25] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 5'd3, 32'h0BADF00D};
        vecs[26] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 5'd3, 32'h0BADF00D};

        reset = 1'b1; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        commit_req = 1'b0; commit_mode = 1'b0; sync_pulse = 1'b0; abort = 1'b0;
        do_reset();

        // Reset state of both instances.
        idle();
        chk("rst_ready0", 32'(wr_ready_0), 32'd1);
        chk("rst_pend0", 32'(pending_0), 32'd0);
        chk("rst_done0", 32'(commit_done_0), 32'd0);
        chk("rst_err0", 32'(wr_err_0), 32'd0);
        chk("rst_cnt0", 32'(cnt_0), 32'd0);
        chk_wide("rst_cfg0", cfg_0, '0);
        chk("rst_ready4", 32'(wr_ready_4), 32'd1);
        chk("rst_tmo4", 32'(timeout_4), 32'd0);
        chk_wide("rst_cfg4", cfg_4, '0);

        for (int i = 0; i <= 26; i++) begin
            drive(vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].cr, vecs[i].cm, vecs[i].sp, vecs[i].ab);
            chk($sformatf("v%0d_ready", i), 32'(wr_ready_0), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_pending", i), 32'(pending_0), 32'(vecs[i].e_pend));
            chk($sformatf("v%0d_done", i), 32'(commit_done_0), 32'(vecs[i].e_done));
            chk($sformatf("v%0d_err", i), 32'(wr_err_0), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_timeout", i), 32'(timeout_0), 32'd0);
            chk($sformatf("v%0d_count", i), 32'(cnt_0), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_word%0d", i, vecs[i].e_idx), word_of(cfg_0, int'(vecs[i].e_idx)), vecs[i].e_word);
        end
        exp_cfg = '0;
        exp_cfg[31:0]   = 32'hFFFFFFFF;
        exp_cfg[63:32]  = 32'h1234ABCD;
        exp_cfg[95:64]  = 32'hA5A5A5A5;
        exp_cfg[127:96] = 32'h0BADF00D;
        chk_wide("table_full_cfg", cfg_0, exp_cfg);

        // Synchronised commit with sync_pulse ten cycles after the request.
        drive(1'b1, 5'd4, 32'h44440004, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            idle();
            chk($sformatf("wait%0d_pending", k), 32'(pending_0), 32'd1);
            chk($sformatf("wait%0d_ready", k), 32'(wr_ready_0), 32'd0);
            chk($sformatf("wait%0d_word4", k), word_of(cfg_0, 4), 32'h0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("wait10_pending", 32'(pending_0), 32'd1);
        chk("wait10_word4", word_of(cfg_0, 4), 32'h0);
        idle();
        chk("sync_apply_done", 32'(commit_done_0), 32'd1);
        chk("sync_apply_pending", 32'(pending_0), 32'd0);
        chk("sync_apply_count", 32'(cnt_0), 32'd5);
        chk("sync_apply_word4", word_of(cfg_0, 4), 32'h44440004);
        exp_cfg[159:128] = 32'h44440004;
        chk_wide("sync_apply_full", cfg_0, exp_cfg);

        // Reset while ARMED discards the pending commit.
        drive(1'b1, 5'd5, 32'h00000055, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        chk("pre_rst_pending", 32'(pending_0), 32'd1);
        @(negedge aclk);
        reset = 1'b1;
        sync_pulse = 1'b1;
        repeat (2) @(negedge aclk);
        reset = 1'b0;
        sync_pulse = 1'b0;
        idle();
        chk("mid_rst_pending", 32'(pending_0), 32'd0);
        chk("mid_rst_ready", 32'(wr_ready_0), 32'd1);
        chk("mid_rst_count", 32'(cnt_0), 32'd0);
        chk_wide("mid_rst_cfg", cfg_0, '0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("post_rst_sync_done", 32'(commit_done_0), 32'd0);
        chk_wide("post_rst_sync_cfg", cfg_0, '0);

        // Timeout = 4: expiry in the 4th ARMED cycle without sync_pulse.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            idle();
            chk($sformatf("tmo_c%0d_pending", k), 32'(pending_4), 32'd1);
            chk($sformatf("tmo_c%0d_timeout", k), 32'(timeout_4), 32'd0);
        end
        idle();
        chk("tmo_c4_timeout", 32'(timeout_4), 32'd1);
        chk("tmo_c4_pending", 32'(pending_4), 32'd1);
        idle();
        chk("tmo_after_timeout", 32'(timeout_4), 32'd0);
        chk("tmo_after_pending", 32'(pending_4), 32'd0);
        chk("tmo_after_ready", 32'(wr_ready_4), 32'd1);
        chk("tmo_after_done", 32'(commit_done_4), 32'd0);
        chk("tmo_after_count", 32'(cnt_4), 32'd0);
        chk_wide("tmo_after_cfg", cfg_4, '0);

        // Timeout = 4: sync_pulse in the 4th ARMED cycle wins.
        drive(1'b1, 5'd6, 32'h66666666, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            idle();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("tmo_sync_c4_timeout", 32'(timeout_4), 32'd0);
        idle();
        chk("tmo_sync_done", 32'(commit_done_4), 32'd1);
        chk("tmo_sync_count", 32'(cnt_4), 32'd1);
        chk("tmo_sync_word6", word_of(cfg_4, 6), 32'h66666666);
        chk("tmo_sync_pending", 32'(pending_4), 32'd0);

        // commit_count wraps from 0xFFFF to 0.
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle();
        chk("count_max", 32'(cnt_0), 32'h0000FFFF);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("count_wrap", 32'(cnt_0), 32'd0);
        chk("count_wrap_done", 32'(commit_done_0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
